// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared definitions for the pong game sequencer.
//   - state_e   : game FSM encoding (also the encoding of the 'state' port)
//   - SCORE_W   : width of the score and max_score registers
//   - *_DEF     : default limits and frame timings
//   - CNT_W     : width of the shared frame counter
//   - sat_inc() : saturating +1 for score registers
package pong_pkg;

  localparam int SCORE_W           = 5;
  localparam int MAX_LIMIT_DEF     = 20;
  localparam int MAX_DEFAULT_DEF   = 5;
  localparam int POINT_HOLD_DEF    = 60;
  localparam int SERVE_TIMEOUT_DEF = 300;

  // Wide enough for the longer of the two frame-count intervals.
  localparam int CNT_W = 9;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    SET       = 3'd1,
    START     = 3'd2,
    PLAY      = 3'd3,
    END_POINT = 3'd4,
    END_GAME  = 3'd5
  } state_e;

  // Increment a score, holding at the all-ones value.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == {SCORE_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + SCORE_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge
//   Brings one raw asynchronous button into the clk_pix domain and turns each
//   press into a single-cycle event, however long the button is held.
//   Ports:
//     clk_pix  in  pixel clock
//     reset    in  synchronous, active-high reset
//     btn_i    in  raw button level (asynchronous)
//     pulse_o  out registered one-cycle event on a rising edge of btn_i
module btn_edge (
  input  logic clk_pix,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Two-flop synchroniser, previous-level flop and registered edge pulse.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Game sequencer for the pong top level: game FSM, scores, max-score setting
//   and serve side. All flops on clk_pix with one synchronous active-high reset.
//   Optional feature: define SERVE_TIMEOUT_EN to auto-serve after SERVE_TIMEOUT
//   frames idle in START; without it START leaves only on a launch event.
//   Ports:
//     clk_pix, reset                 clock and synchronous reset
//     frame_tick                     one-cycle pulse per frame
//     btn_launch, btn_up, btn_down   raw asynchronous buttons
//     left_hit, right_hit            goal pulses from the ball engine
//     state                          current state (pong_pkg::state_e)
//     menu_sel                       menu highlight (0 top, 1 bottom)
//     max_score, score_p1, score_p2  winning score and player scores
//     serve_p2                       0 = p1 serves, 1 = p2 serves
//     play_en                        high while in PLAY
//     ball_reset                     one-cycle pulse on entry to START
//     game_over                      high while in END_GAME
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int MAX_LIMIT   = MAX_LIMIT_DEF,
  parameter int MAX_DEFAULT = MAX_DEFAULT_DEF,
  parameter int POINT_HOLD  = POINT_HOLD_DEF
`ifdef SERVE_TIMEOUT_EN
  ,
  parameter int SERVE_TIMEOUT = SERVE_TIMEOUT_DEF
`endif
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_launch,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               left_hit,
  input  logic               right_hit,
  output logic [2:0]         state,
  output logic               menu_sel,
  output logic [SCORE_W-1:0] max_score,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_p2,
  output logic               play_en,
  output logic               ball_reset,
  output logic               game_over
);

  logic launch_ev;
  logic up_ev;
  logic down_ev;

  btn_edge u_btn_launch (.clk_pix(clk_pix), .reset(reset), .btn_i(btn_launch), .pulse_o(launch_ev));
  btn_edge u_btn_up     (.clk_pix(clk_pix), .reset(reset), .btn_i(btn_up),     .pulse_o(up_ev));
  btn_edge u_btn_down   (.clk_pix(clk_pix), .reset(reset), .btn_i(btn_down),   .pulse_o(down_ev));

  state_e             state_q,      state_d;
  logic               menu_sel_q,   menu_sel_d;
  logic [SCORE_W-1:0] max_q,        max_d;
  logic [SCORE_W-1:0] p1_q,         p1_d;
  logic [SCORE_W-1:0] p2_q,         p2_d;
  logic               serve_q,      serve_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic               ball_reset_q, ball_reset_d;
  logic               play_en_q,    play_en_d;
  logic               game_over_q,  game_over_d;
  logic [CNT_W-1:0]   cnt_nxt;

  // Next-state, score/setting updates and registered output decode.
  always_comb begin
    state_d    = state_q;
    menu_sel_d = menu_sel_q;
    max_d      = max_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    serve_d    = serve_q;
    cnt_nxt    = cnt_q;

    case (state_q)
      MENU: begin
        if (up_ev || down_ev) begin
          menu_sel_d = ~menu_sel_q;
        end else begin
          menu_sel_d = menu_sel_q;
        end
        if (launch_ev) begin
          state_d = SET;
        end else begin
          state_d = MENU;
        end
      end

      SET: begin
        // Simultaneous up and down cancel each other.
        if (up_ev && !down_ev && (max_q < SCORE_W'(MAX_LIMIT))) begin
          max_d = max_q + SCORE_W'(1);
        end else if (down_ev && !up_ev && (max_q > SCORE_W'(1))) begin
          max_d = max_q - SCORE_W'(1);
        end else begin
          max_d = max_q;
        end
        if (launch_ev) begin
          state_d = START;
          p1_d    = '0;
          p2_d    = '0;
          serve_d = 1'b0;
        end else begin
          state_d = SET;
        end
      end

      START: begin
        if (launch_ev) begin
          state_d = PLAY;
`ifdef SERVE_TIMEOUT_EN
        end else if (frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_TIMEOUT - 1)) begin
            state_d = PLAY;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
`endif
        end else begin
          state_d = START;
        end
      end

      PLAY: begin
        // left_hit has priority; a simultaneous right_hit is dropped.
        if (left_hit) begin
          p2_d    = sat_inc(p2_q);
          serve_d = 1'b0;
          state_d = END_POINT;
        end else if (right_hit) begin
          p1_d    = sat_inc(p1_q);
          serve_d = 1'b1;
          state_d = END_POINT;
        end else begin
          state_d = PLAY;
        end
      end

      END_POINT: begin
        // Scores are frozen here, so the win check holds from the first cycle.
        if ((p1_q == max_q) || (p2_q == max_q)) begin
          state_d = END_GAME;
        end else if (frame_tick) begin
          if (cnt_q == CNT_W'(POINT_HOLD - 1)) begin
            state_d = START;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = END_POINT;
        end
      end

      END_GAME: begin
        if (launch_ev) begin
          state_d = MENU;
          p1_d    = '0;
          p2_d    = '0;
        end else begin
          state_d = END_GAME;
        end
      end

      default: begin
        state_d = MENU;
      end
    endcase

    // The frame counter restarts on every state change.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_nxt;
    end

    ball_reset_d = (state_d == START) && (state_q != START);
    play_en_d    = (state_d == PLAY);
    game_over_d  = (state_d == END_GAME);
  end

  // State, score, setting and output registers.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q      <= MENU;
      menu_sel_q   <= 1'b0;
      max_q        <= SCORE_W'(MAX_DEFAULT);
      p1_q         <= '0;
      p2_q         <= '0;
      serve_q      <= 1'b0;
      cnt_q        <= '0;
      ball_reset_q <= 1'b0;
      play_en_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      menu_sel_q   <= menu_sel_d;
      max_q        <= max_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      serve_q      <= serve_d;
      cnt_q        <= cnt_d;
      ball_reset_q <= ball_reset_d;
      play_en_q    <= play_en_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state      = state_q;
  assign menu_sel   = menu_sel_q;
  assign max_score  = max_q;
  assign score_p1   = p1_q;
  assign score_p2   = p2_q;
  assign serve_p2   = serve_q;
  assign play_en    = play_en_q;
  assign ball_reset = ball_reset_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
//   Directed self-checking bench for pong_game_ctrl (default build).
module tb_pong_game_ctrl;

  logic       clk_pix = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_launch = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       left_hit = 1'b0;
  logic       right_hit = 1'b0;
  logic [2:0] state;
  logic       menu_sel;
  logic [4:0] max_score;
  logic [4:0] score_p1;
  logic [4:0] score_p2;
  logic       serve_p2;
  logic       play_en;
  logic       ball_reset;
  logic       game_over;

  int checks = 0;
  int failures = 0;
  int br_cnt = 0;
  int toggles = 0;

  localparam logic [2:0] S_MENU = 3'd0, S_SET = 3'd1, S_START = 3'd2,
                         S_PLAY = 3'd3, S_END_POINT = 3'd4, S_END_GAME = 3'd5;

  pong_game_ctrl dut (
    .clk_pix(clk_pix), .reset(reset), .frame_tick(frame_tick),
    .btn_launch(btn_launch), .btn_up(btn_up), .btn_down(btn_down),
    .left_hit(left_hit), .right_hit(right_hit),
    .state(state), .menu_sel(menu_sel), .max_score(max_score),
    .score_p1(score_p1), .score_p2(score_p2), .serve_p2(serve_p2),
    .play_en(play_en), .ball_reset(ball_reset), .game_over(game_over)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Press a button combination for 5 cycles, release for 5; counts ball_reset cycles.
  task automatic press(input logic l, input logic u, input logic d);
    br_cnt = 0;
    btn_launch = l; btn_up = u; btn_down = d;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ball_reset) br_cnt++;
    end
    btn_launch = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ball_reset) br_cnt++;
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic hit(input logic l, input logic r);
    left_hit = l; right_hit = r;
    tick();
    left_hit = 1'b0; right_hit = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'(S_MENU));
    check({tag, "_menu_sel"}, 32'(menu_sel), 32'd0);
    check({tag, "_max"}, 32'(max_score), 32'd5);
    check({tag, "_p1"}, 32'(score_p1), 32'd0);
    check({tag, "_p2"}, 32'(score_p2), 32'd0);
    check({tag, "_serve"}, 32'(serve_p2), 32'd0);
    check({tag, "_play_en"}, 32'(play_en), 32'd0);
    check({tag, "_ball_reset"}, 32'(ball_reset), 32'd0);
    check({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    logic prev_sel;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Held button gives exactly one event.
    prev_sel = menu_sel;
    btn_up = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (menu_sel != prev_sel) toggles++;
      prev_sel = menu_sel;
    end
    btn_up = 1'b0;
    repeat (5) tick();
    check("hold_one_event", 32'(toggles), 32'd1);
    check("hold_menu_sel", 32'(menu_sel), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("menu_down_toggle", 32'(menu_sel), 32'd0);

    // Hits ignored outside PLAY.
    hit(1'b1, 1'b0);
    tick();
    check("menu_hit_ignored_p2", 32'(score_p2), 32'd0);
    check("menu_hit_ignored_state", 32'(state), 32'(S_MENU));

    press(1'b1, 1'b0, 1'b0);
    check("to_set", 32'(state), 32'(S_SET));
    for (int i = 0; i < 20; i++) press(1'b0, 1'b1, 1'b0);
    check("max_sat_hi", 32'(max_score), 32'd20);
    for (int i = 0; i < 25; i++) press(1'b0, 1'b0, 1'b1);
    check("max_sat_lo", 32'(max_score), 32'd1);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0);
    check("max_back_5", 32'(max_score), 32'd5);
    press(1'b0, 1'b1, 1'b1);
    check("max_up_down_cancel", 32'(max_score), 32'd5);

    press(1'b1, 1'b0, 1'b0);
    check("to_start", 32'(state), 32'(S_START));
    check("ball_reset_one_cycle", 32'(br_cnt), 32'd1);
    check("start_p1", 32'(score_p1), 32'd0);
    check("start_p2", 32'(score_p2), 32'd0);
    check("start_max", 32'(max_score), 32'd5);

    press(1'b1, 1'b0, 1'b0);
    check("to_play", 32'(state), 32'(S_PLAY));
    check("play_en", 32'(play_en), 32'd1);

    hit(1'b0, 1'b1);
    check("rhit_p1", 32'(score_p1), 32'd1);
    check("rhit_serve", 32'(serve_p2), 32'd1);
    check("rhit_state", 32'(state), 32'(S_END_POINT));
    check("rhit_play_en", 32'(play_en), 32'd0);
    frames(59);
    check("hold_59", 32'(state), 32'(S_END_POINT));
    frames(1);
    check("hold_60_start", 32'(state), 32'(S_START));

    press(1'b1, 1'b0, 1'b0);
    check("to_play2", 32'(state), 32'(S_PLAY));
    hit(1'b1, 1'b1);
    check("both_p2", 32'(score_p2), 32'd1);
    check("both_p1", 32'(score_p1), 32'd1);
    check("both_serve", 32'(serve_p2), 32'd0);
    check("both_state", 32'(state), 32'(S_END_POINT));

    frames(60);
    press(1'b1, 1'b0, 1'b0);
    check("to_play3", 32'(state), 32'(S_PLAY));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");

    // Short game to max_score = 2.
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b1);
    check("max_2", 32'(max_score), 32'd2);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("g2_play", 32'(state), 32'(S_PLAY));
    hit(1'b1, 1'b0);
    check("g2_p2_1", 32'(score_p2), 32'd1);
    frames(60);
    check("g2_start", 32'(state), 32'(S_START));
    press(1'b1, 1'b0, 1'b0);
    hit(1'b1, 1'b0);
    check("g2_p2_2", 32'(score_p2), 32'd2);
    check("g2_end_point", 32'(state), 32'(S_END_POINT));
    tick();
    check("g2_end_game", 32'(state), 32'(S_END_GAME));
    check("g2_game_over", 32'(game_over), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    check("g2_menu", 32'(state), 32'(S_MENU));
    check("g2_p1_clr", 32'(score_p1), 32'd0);
    check("g2_p2_clr", 32'(score_p2), 32'd0);
    check("g2_game_over_clr", 32'(game_over), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
